// File: rtl/fetch_queue.sv
// Instruction-fetch front end. It owns the fetch PC and keeps at most one
// request outstanding to a stallable instruction memory. Returned instructions
// are tagged with their PC and buffered in a DEPTH-entry FIFO for decode.
// Redirect flushes the FIFO and restarts fetch. A response that is still in
// flight across a redirect is dropped when it arrives.
module fetch_queue #(
  parameter int          DATA_W   = 16,
  parameter int          ADDR_W   = 16,
  parameter int          DEPTH    = 4,
  parameter int          PC_INC   = 2,
  parameter int unsigned RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req,
  output logic [ADDR_W-1:0]        imem_addr,
  input  logic                     imem_ready,
  input  logic                     imem_valid,
  input  logic [DATA_W-1:0]        imem_data,
  output logic                     inst_valid,
  output logic [DATA_W-1:0]        inst,
  output logic [ADDR_W-1:0]        inst_pc,
  output logic [ADDR_W-1:0]        inst_pc_next,
  input  logic                     inst_ready,
  input  logic                     redirect_en,
  input  logic [ADDR_W-1:0]        redirect_pc,
  input  logic                     halt,
  output logic                     halted,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     err
);

  localparam int                PTR_W   = $clog2(DEPTH);
  localparam int                CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] INC_C   = ADDR_W'(PC_INC);
  localparam logic [ADDR_W-1:0] RST_PC  = ADDR_W'(RESET_PC);

  // Sequential PC step; the add wraps modulo 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_step(input logic [ADDR_W-1:0] pc);
    return pc + INC_C;
  endfunction

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] req_pc;
  logic              outstanding;
  logic              drop;
  logic              halt_l;
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [DATA_W-1:0] fifo_data [DEPTH];
  logic [ADDR_W-1:0] fifo_pc   [DEPTH];

  logic accept;
  logic resp;
  logic push;
  logic pop;

  // Handshake decode. Requests are held off while in reset, halting,
  // redirecting, waiting on memory, or out of FIFO space.
  always_comb begin
    imem_req   = !rst && !halt_l && !halt && !outstanding && !redirect_en &&
                 (count < DEPTH_C);
    accept     = imem_req && imem_ready;
    resp       = imem_valid && outstanding;
    push       = resp && !drop && !redirect_en;
    inst_valid = (count != '0);
    pop        = inst_valid && inst_ready && !redirect_en;
  end

  assign imem_addr    = fetch_pc;
  assign inst         = fifo_data[rd_ptr];
  assign inst_pc      = fifo_pc[rd_ptr];
  assign inst_pc_next = pc_step(fifo_pc[rd_ptr]);
  assign halted       = halt_l && !outstanding;

  // Fetch PC and request tracking. A redirect that overtakes an in-flight
  // request arms drop so the stale response is discarded on arrival.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc    <= RST_PC;
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else begin
      if (redirect_en) begin
        fetch_pc <= redirect_pc;
      end else if (accept) begin
        fetch_pc <= pc_step(fetch_pc);
      end
      if (accept) begin
        outstanding <= 1'b1;
      end else if (resp) begin
        outstanding <= 1'b0;
      end
      if (redirect_en && outstanding && !imem_valid) begin
        drop <= 1'b1;
      end else if (resp) begin
        drop <= 1'b0;
      end
    end
  end

  // Sticky halt and unsolicited-response error flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      halt_l <= 1'b0;
      err    <= 1'b0;
    end else begin
      if (halt) begin
        halt_l <= 1'b1;
      end
      if (imem_valid && !outstanding) begin
        err <= 1'b1;
      end
    end
  end

  // FIFO pointers and occupancy. Redirect empties the queue and overrides
  // any push or pop in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // Capture the PC of each accepted request so the response can be tagged.
  always_ff @(posedge clk) begin
    if (accept) begin
      req_pc <= fetch_pc;
    end
  end

  // FIFO storage. This is data only, so it has no reset; entries are
  // qualified by count.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= imem_data;
      fifo_pc[wr_ptr]   <= req_pc;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue. A queue-based reference model and a small
// randomized-latency instruction memory drive a linear sequence of
// directed and random phases.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ready;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        inst_valid;
  logic [15:0] inst;
  logic [15:0] inst_pc;
  logic [15:0] inst_pc_next;
  logic        inst_ready;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        halt;
  logic        halted;
  logic [2:0]  count;
  logic        err;

  fetch_queue #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .PC_INC(2), .RESET_PC(0)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_pc_next(inst_pc_next), .inst_ready(inst_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .halt(halt), .halted(halted), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: architectural state plus a queue of {data, pc}.
  logic [15:0] m_pc;
  logic [15:0] m_req_pc;
  bit          m_out, m_drop, m_halt, m_err;
  logic [31:0] m_q[$];

  // Memory model: a single pending response after a random delay.
  bit          mem_pend;
  int          mem_dly;
  logic [15:0] mem_dat;

  // Stimulus knobs.
  int          p_ready, p_iready, p_redir, max_lat;
  bit          f_redir, f_inject, halt_knob;
  logic [15:0] f_redir_pc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit model_req();
    return !m_halt && !halt && !m_out && !redirect_en && (m_q.size() < 4);
  endfunction

  task automatic model_reset();
    m_pc = 16'h0000; m_req_pc = 16'h0000;
    m_out = 0; m_drop = 0; m_halt = 0; m_err = 0;
    m_q.delete();
    mem_pend = 0; mem_dly = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    imem_valid = 1'b0; imem_ready = 1'b0; inst_ready = 1'b0;
    redirect_en = 1'b0; halt = 1'b0;
    #2;
    chk("rst_imem_req", imem_req, 0);
    chk("rst_inst_valid", inst_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_err", err, 0);
    chk("rst_count", count, 0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic cycle();
    bit          exp_req, acc, rsp, pop;
    logic [15:0] nxt;
    imem_ready = ($urandom_range(0, 99) < p_ready);
    inst_ready = ($urandom_range(0, 99) < p_iready);
    if (f_redir) begin
      redirect_en = 1'b1; redirect_pc = f_redir_pc;
    end else begin
      redirect_en = ($urandom_range(0, 99) < p_redir);
      redirect_pc = 16'($urandom) & 16'hFFFE;
    end
    halt = halt_knob;
    if (f_inject) begin
      imem_valid = 1'b1; imem_data = 16'($urandom);
    end else begin
      imem_valid = mem_pend && (mem_dly == 0);
      imem_data  = mem_pend ? mem_dat : 16'($urandom);
    end
    @(negedge clk);
    exp_req = model_req();
    chk("imem_req", imem_req, exp_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("inst_valid", inst_valid, m_q.size() != 0);
    if (m_q.size() != 0) begin
      nxt = m_q[0][15:0] + 16'd2;
      chk("inst", inst, m_q[0][31:16]);
      chk("inst_pc", inst_pc, m_q[0][15:0]);
      chk("inst_pc_next", inst_pc_next, nxt);
    end
    chk("count", count, 32'(m_q.size()));
    chk("halted", halted, m_halt && !m_out);
    chk("err", err, m_err);
    acc = exp_req && imem_ready;
    rsp = imem_valid && m_out;
    pop = (m_q.size() != 0) && inst_ready && !redirect_en;
    if (imem_valid && !m_out) m_err = 1;
    if (halt) m_halt = 1;
    if (redirect_en) begin
      m_q.delete();
      m_pc = redirect_pc;
      if (m_out && !imem_valid) m_drop = 1;
      else if (rsp) begin m_out = 0; m_drop = 0; end
    end else begin
      if (pop) void'(m_q.pop_front());
      if (rsp) begin
        if (m_drop) m_drop = 0;
        else m_q.push_back({imem_data, m_req_pc});
        m_out = 0;
      end
      if (acc) begin
        m_req_pc = m_pc; m_pc = m_pc + 16'd2; m_out = 1;
      end
    end
    if (mem_pend) begin
      if (mem_dly == 0) mem_pend = 0;
      else mem_dly--;
    end
    if (acc) begin
      mem_pend = 1; mem_dly = $urandom_range(0, max_lat - 1); mem_dat = 16'($urandom);
    end
    @(posedge clk); #1;
    f_redir = 0; f_inject = 0;
  endtask

  initial begin
    bit found;
    rst = 1'b0; imem_valid = 1'b0; imem_ready = 1'b0; imem_data = '0;
    inst_ready = 1'b0; redirect_en = 1'b0; redirect_pc = '0; halt = 1'b0;
    f_redir = 0; f_inject = 0; halt_knob = 0; f_redir_pc = '0;
    #1;
    do_reset();

    // Streaming: always ready, single-cycle latency, decode always ready.
    p_ready = 100; p_iready = 100; p_redir = 0; max_lat = 1;
    for (int i = 0; i < 12; i++) cycle();

    // Decode stalled: the FIFO fills to DEPTH and issue stops.
    p_iready = 0;
    for (int i = 0; i < 20; i++) cycle();
    chk("full_count", count, 4);
    chk("full_no_req", imem_req, 0);
    p_iready = 100; cycle();
    p_iready = 0;
    chk("one_pop_count", count, 3);
    for (int i = 0; i < 4; i++) cycle();

    // Redirect while a request is in flight with entries buffered.
    do_reset();
    p_ready = 100; p_iready = 0; max_lat = 3;
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (m_out && mem_pend && mem_dly > 0 && m_q.size() >= 2) found = 1;
      else cycle();
    end
    chk("redir_setup", found, 1);
    f_redir = 1; f_redir_pc = 16'h0100;
    cycle();
    chk("redir_count", count, 0);
    p_iready = 100;
    for (int i = 0; i < 16; i++) cycle();

    // PC wrap at the top of the address space.
    max_lat = 1;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (!m_out) found = 1;
      else cycle();
    end
    chk("wrap_setup", found, 1);
    f_redir = 1; f_redir_pc = 16'hFFFE;
    cycle();
    cycle();
    chk("wrap_addr", imem_addr, 16'h0000);
    for (int i = 0; i < 8; i++) cycle();

    // Random traffic with occasional redirects.
    p_ready = 70; p_iready = 60; p_redir = 4; max_lat = 3;
    for (int i = 0; i < 1500; i++) cycle();

    // Halt while a request is in flight.
    p_redir = 0; p_ready = 100; p_iready = 50;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (m_out) found = 1;
      else cycle();
    end
    chk("halt_setup", found, 1);
    halt_knob = 1; cycle(); halt_knob = 0;
    p_iready = 100;
    for (int i = 0; i < 12; i++) cycle();
    chk("halt_halted", halted, 1);
    chk("halt_no_req", imem_req, 0);
    chk("halt_drained", count, 0);

    // Unsolicited response sets the sticky error.
    f_inject = 1; cycle();
    chk("err_set", err, 1);
    for (int i = 0; i < 3; i++) cycle();
    chk("err_sticky", err, 1);
    do_reset();
    chk("err_cleared", err, 0);

    // More random traffic after the mid-run reset.
    p_ready = 60; p_iready = 70; p_redir = 3; max_lat = 2;
    for (int i = 0; i < 300; i++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
